// File: rtl/exception_ctrl.sv
// Trap/exception controller: captures syscalls and interrupts at instruction
// boundaries, redirects the CPU to the handler and returns on eret.
module exception_ctrl #(
    parameter logic [31:0] VECTOR        = 32'h80000000,
    parameter logic [3:0]  SYSCALL_CAUSE = 4'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq,
    input  logic [3:0]  icause,
    output logic        iack,
    input  logic        instr_done,
    input  logic [31:0] pc_next,
    input  logic        is_syscall,
    input  logic        is_eret,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        in_handler
);

    localparam logic [31:0] ADDR_EPC   = 32'h80004000;
    localparam logic [31:0] ADDR_CAUSE = 32'h80004004;
    localparam logic [31:0] ADDR_IE    = 32'h80004008;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic        ie_q, ie_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [1:0]  rst_sync_q;
    logic        run;

    // Reset asserts asynchronously but releases through two flops, so no
    // state moves until the synchroniser has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        ie_d          = ie_q;
        redirect_d    = 1'b0;
        redirect_pc_d = VECTOR;

        if (we && (a == ADDR_EPC)) begin
            epc_d = d;
        end
        if (we && (a == ADDR_IE) && (state_q == IDLE)) begin
            ie_d = d[0];
        end

        // Trap capture and eret are assigned after bus writes so they win.
        case (state_q)
            IDLE: begin
                if (instr_done) begin
                    if (is_syscall) begin
                        epc_d      = pc_next;
                        cause_d    = SYSCALL_CAUSE;
                        ie_d       = 1'b0;
                        redirect_d = 1'b1;
                        state_d    = HANDLER;
                    end else if (irq && ie_q) begin
                        epc_d      = pc_next;
                        cause_d    = icause;
                        ie_d       = 1'b0;
                        redirect_d = 1'b1;
                        state_d    = ACK;
                    end
                end
            end
            ACK: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                if (instr_done && is_eret) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = epc_q;
                    ie_d          = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            epc_q         <= 32'h0;
            cause_q       <= 4'h0;
            ie_q          <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= VECTOR;
        end else if (run) begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            ie_q          <= ie_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign iack        = (state_q == ACK);
    assign in_handler  = (state_q != IDLE);
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

    always_comb begin
        spo = 32'h0;
        case (a)
            ADDR_EPC:   spo = epc_q;
            ADDR_CAUSE: spo = {28'h0, cause_q};
            ADDR_IE:    spo = {31'h0, ie_q};
            default:    spo = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus queues expected redirects and
// register reads; a negedge monitor pops and compares.
module tb_exception_ctrl;

    localparam logic [31:0] VEC    = 32'h80000000;
    localparam logic [31:0] A_EPC  = 32'h80004000;
    localparam logic [31:0] A_CAU  = 32'h80004004;
    localparam logic [31:0] A_IE   = 32'h80004008;
    localparam logic [31:0] A_BAD  = 32'h8000400C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq = 1'b0;
    logic [3:0]  icause = 4'h0;
    logic        iack;
    logic        instr_done = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic        is_syscall = 1'b0;
    logic        is_eret = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] a = 32'h0;
    logic [31:0] d = 32'h0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic        in_handler;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic        inh;
    } redir_t;

    redir_t      redir_q[$];
    logic [31:0] rd_q[$];
    logic        rd_valid = 1'b0;
    int          redir_n = 0;

    exception_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .icause(icause), .iack(iack),
        .instr_done(instr_done), .pc_next(pc_next), .is_syscall(is_syscall),
        .is_eret(is_eret), .redirect(redirect), .redirect_pc(redirect_pc),
        .a(a), .d(d), .we(we), .spo(spo), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (redirect) begin
            total++;
            if (redir_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_redirect: got pc=%h iack=%b, required no redirect", redirect_pc, iack);
            end else begin
                redir_t e;
                e = redir_q.pop_front();
                redir_n++;
                if (redirect_pc !== e.pc || iack !== e.ack || in_handler !== e.inh) begin
                    bad++;
                    $display("FAIL redirect#%0d: got pc=%h iack=%b inh=%b, required pc=%h iack=%b inh=%b",
                             redir_n, redirect_pc, iack, in_handler, e.pc, e.ack, e.inh);
                end else begin
                    $display("redirect#%0d pc=%h iack=%b inh=%b ok", redir_n, redirect_pc, iack, in_handler);
                end
            end
        end else if (iack) begin
            total++;
            bad++;
            $display("FAIL stray_iack: got iack=1 without redirect, required 0");
        end
        if (rd_valid) begin
            logic [31:0] e;
            total++;
            e = rd_q.pop_front();
            if (spo !== e) begin
                bad++;
                $display("FAIL read@%h: got %h, required %h", a, spo, e);
            end else begin
                $display("read@%h = %h ok", a, spo);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end else begin
            $display("%s = %h ok", name, got);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        rd_q.push_back(exp);
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] val);
        a = addr;
        d = val;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic boundary(input logic [31:0] pc, input logic sys, input logic er);
        instr_done = 1'b1;
        pc_next = pc;
        is_syscall = sys;
        is_eret = er;
        step();
        instr_done = 1'b0;
        is_syscall = 1'b0;
        is_eret = 1'b0;
    endtask

    task automatic expect_redir(input logic [31:0] pc, input logic ack, input logic inh);
        redir_t e;
        e.pc = pc;
        e.ack = ack;
        e.inh = inh;
        redir_q.push_back(e);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_iack", {31'h0, iack}, 32'h0);
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, VEC);
        chk("rst_in_handler", {31'h0, in_handler}, 32'h0);
        rst_n = 1'b1;
        repeat (4) step();

        rd(A_EPC, 32'h0);
        rd(A_CAU, 32'h0);
        rd(A_IE, 32'h0);

        // IE clear: held irq must be ignored at every boundary.
        irq = 1'b1;
        icause = 4'd8;
        for (int i = 0; i < 20; i++) begin
            boundary(32'h1000 + 32'(i * 4), 1'b0, 1'b0);
        end
        wr(A_IE, 32'h1);
        rd(A_IE, 32'h1);
        expect_redir(VEC, 1'b1, 1'b1);
        boundary(32'h104, 1'b0, 1'b0);
        step();
        boundary(32'h108, 1'b0, 1'b0);
        boundary(32'h10C, 1'b1, 1'b0);
        irq = 1'b0;
        rd(A_EPC, 32'h104);
        rd(A_CAU, 32'h8);
        rd(A_IE, 32'h0);
        wr(A_IE, 32'h1);
        rd(A_IE, 32'h0);
        expect_redir(32'h104, 1'b0, 1'b0);
        boundary(32'h110, 1'b0, 1'b1);
        rd(A_IE, 32'h1);

        // Syscall beats a pending irq; irq is taken after return.
        irq = 1'b1;
        icause = 4'd5;
        expect_redir(VEC, 1'b0, 1'b1);
        boundary(32'h200, 1'b1, 1'b0);
        rd(A_CAU, 32'd11);
        rd(A_EPC, 32'h200);
        rd(A_IE, 32'h0);
        expect_redir(32'h200, 1'b0, 1'b0);
        boundary(32'h204, 1'b0, 1'b1);
        expect_redir(VEC, 1'b1, 1'b1);
        boundary(32'h300, 1'b0, 1'b0);
        irq = 1'b0;
        rd(A_CAU, 32'h5);
        rd(A_EPC, 32'h300);
        expect_redir(32'h300, 1'b0, 1'b0);
        boundary(32'h304, 1'b0, 1'b1);

        // eret outside a handler does nothing; bus map checks.
        boundary(32'h400, 1'b0, 1'b1);
        wr(A_EPC, 32'hDEAD0000);
        rd(A_EPC, 32'hDEAD0000);
        wr(A_CAU, 32'h7);
        rd(A_CAU, 32'h5);
        rd(A_BAD, 32'h0);

        // EPC bus write in the capture cycle loses to the trap.
        a = A_EPC;
        d = 32'h12345678;
        we = 1'b1;
        expect_redir(VEC, 1'b0, 1'b1);
        boundary(32'h500, 1'b1, 1'b0);
        we = 1'b0;
        rd(A_EPC, 32'h500);
        expect_redir(32'h500, 1'b0, 1'b0);
        boundary(32'h504, 1'b0, 1'b1);

        // Reset in the ACK cycle abandons the trap.
        irq = 1'b1;
        icause = 4'd3;
        expect_redir(VEC, 1'b1, 1'b1);
        boundary(32'h600, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        irq = 1'b0;
        #1;
        chk("mid_rst_iack", {31'h0, iack}, 32'h0);
        chk("mid_rst_redirect", {31'h0, redirect}, 32'h0);
        chk("mid_rst_redirect_pc", redirect_pc, VEC);
        chk("mid_rst_in_handler", {31'h0, in_handler}, 32'h0);
        rd(A_EPC, 32'h0);
        rd(A_CAU, 32'h0);
        rd(A_IE, 32'h0);
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_in_handler", {31'h0, in_handler}, 32'h0);

        chk("pending_redirects", 32'(redir_q.size()), 32'h0);
        chk("redirects_seen", 32'(redir_n), 32'd9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
